// File: rtl/logIP_pkg.sv
// Shared types and helpers for the logic analyzer readout path.
package logIP_pkg;

    // Largest number of byte lanes a sample may have (128-bit samples).
    localparam int MAX_BYTES  = 16;
    localparam int BYTE_IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } readout_state_t;

    // Result of a byte-lane search: lane index, or none=1 when no lane qualifies.
    typedef struct packed {
        logic                  none;
        logic [BYTE_IDX_W-1:0] idx;
    } byte_sel_t;

    // Lowest enabled lane whose index is at or above current.
    // mask has bit k=1 when lane k is enabled; unused upper lanes must be 0.
    function automatic byte_sel_t next_byte(
        input logic [MAX_BYTES-1:0] mask,
        input logic [BYTE_IDX_W:0]  current
    );
        byte_sel_t sel;
        sel.none = 1'b1;
        sel.idx  = '0;
        // Scan downward so the lowest qualifying lane is the one left in sel.
        for (int i = MAX_BYTES - 1; i >= 0; i--) begin
            if (mask[i] && ((BYTE_IDX_W + 1)'(i) >= current)) begin
                sel.none = 1'b0;
                sel.idx  = BYTE_IDX_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sample_readout.sv
// Capture-memory readout engine: fetches rd_cnt samples, one strobe each,
// and serialises the enabled bytes of every sample LSB first to a byte link.
module sample_readout
    import logIP_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic               clk_i,
    input  logic               rst_in,
    input  logic               start_i,
    input  logic [DEPTH:0]     rd_cnt_i,
    input  logic [WIDTH/8-1:0] grp_dis_i,
    output logic               mem_read_o,
    input  logic [WIDTH-1:0]   mem_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int NB = WIDTH / 8;
    localparam logic [DEPTH:0] CNT_ONE = {{DEPTH{1'b0}}, 1'b1};

    readout_state_t        state_reg;
    logic [DEPTH:0]        cnt_reg;
    logic [NB-1:0]         mask_reg;   // enabled lanes (inverse of the disable mask)
    logic [WIDTH-1:0]      sample_reg;
    logic [BYTE_IDX_W-1:0] idx_reg;

    logic [MAX_BYTES-1:0]  en_ext;
    logic [BYTE_IDX_W:0]   after_idx;
    byte_sel_t             first_sel;
    byte_sel_t             next_sel;

    // Lane search: first lane of a fresh sample, and the lane following the current one.
    assign en_ext    = MAX_BYTES'(mask_reg);
    assign after_idx = {1'b0, idx_reg} + 1'b1;
    assign first_sel = next_byte(en_ext, '0);
    assign next_sel  = next_byte(en_ext, after_idx);

    // Readout FSM with registered strobe, byte stream and status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mask_reg   <= '0;
            sample_reg <= '0;
            idx_reg    <= '0;
            mem_read_o <= 1'b0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= 8'h00;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            // Strobe and done are single-cycle unless a branch re-asserts them.
            mem_read_o <= 1'b0;
            done_o     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy_o     <= 1'b0;
                    tx_valid_o <= 1'b0;
                    if (start_i) begin
                        cnt_reg  <= rd_cnt_i;
                        mask_reg <= ~grp_dis_i;
                        busy_o   <= 1'b1;
                        if (rd_cnt_i == '0) begin
                            state_reg <= DONE;
                            done_o    <= 1'b1;
                        end else begin
                            state_reg  <= FETCH;
                            mem_read_o <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    // Read data arrives during LATCH, one cycle after the strobe.
                    state_reg <= LATCH;
                end

                LATCH: begin
                    sample_reg <= mem_i;
                    cnt_reg    <= cnt_reg - CNT_ONE;
                    idx_reg    <= first_sel.idx;
                    if (first_sel.none) begin
                        // Every lane disabled: consume the sample without sending.
                        if (cnt_reg != CNT_ONE) begin
                            state_reg  <= FETCH;
                            mem_read_o <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            done_o    <= 1'b1;
                        end
                    end else begin
                        state_reg  <= SEND;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= mem_i[{first_sel.idx, 3'b000} +: 8];
                    end
                end

                SEND: begin
                    // tx_valid_o is always high here, so tx_ready_i alone marks a handshake;
                    // without it the byte and valid simply hold.
                    if (tx_ready_i) begin
                        if (!next_sel.none) begin
                            idx_reg   <= next_sel.idx;
                            tx_data_o <= sample_reg[{next_sel.idx, 3'b000} +: 8];
                        end else begin
                            tx_valid_o <= 1'b0;
                            if (cnt_reg != '0) begin
                                state_reg  <= FETCH;
                                mem_read_o <= 1'b1;
                            end else begin
                                state_reg <= DONE;
                                done_o    <= 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    busy_o    <= 1'b0;
                end

                default: begin
                    state_reg  <= IDLE;
                    busy_o     <= 1'b0;
                    tx_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_readout.sv
// Directed bench for sample_readout with a one-cycle-latency memory model.
module tb_sample_readout;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int NB    = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DEPTH:0]   rd_cnt;
    logic [NB-1:0]    grp_dis;
    logic             mem_read;
    logic [WIDTH-1:0] mem_i = '0;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    // Memory model state (written only by the model process)
    logic [WIDTH-1:0] mem_data [0:63];
    int               mem_idx = 0;
    int               mem_base = 0;

    // Monitor state (written only by the monitor process)
    int        cyc = 0;
    int        rd_total = 0;
    int        valid_total = 0;
    int        done_total = 0;
    int        byte_total = 0;
    int        last_done_cyc = 0;
    logic [7:0] byte_log [0:255];
    logic      prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Per-test snapshots
    int rd_base, valid_base, done_base, byte_base, start_cyc;

    always #5 clk = ~clk;

    sample_readout #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_in     (rst_n),
        .start_i    (start),
        .rd_cnt_i   (rd_cnt),
        .grp_dis_i  (grp_dis),
        .mem_read_o (mem_read),
        .mem_i      (mem_i),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Capture memory: data for a strobe is presented one cycle later
    always @(posedge clk) begin
        if (mem_read) begin
            mem_i   <= mem_data[(mem_idx - mem_base) & 63];
            mem_idx <= mem_idx + 1;
        end
    end

    // Monitor: counts strobes, valid cycles, accepted bytes, done pulses; checks hold stability
    always @(negedge clk) begin
        if (prev_hold) begin
            check("hold_valid", 64'(tx_valid), 64'd1);
            check("hold_data", 64'(tx_data), 64'(prev_data));
        end
        prev_hold <= tx_valid && !tx_ready && rst_n;
        prev_data <= tx_data;
        if (mem_read) rd_total <= rd_total + 1;
        if (tx_valid) valid_total <= valid_total + 1;
        if (tx_valid && tx_ready) begin
            byte_log[byte_total & 255] <= tx_data;
            byte_total <= byte_total + 1;
        end
        if (done) begin
            done_total    <= done_total + 1;
            last_done_cyc <= cyc;
        end
    end

    task automatic start_readout(input logic [DEPTH:0] cnt, input logic [NB-1:0] dis);
        @(negedge clk);
        rd_base    = rd_total;
        valid_base = valid_total;
        done_base  = done_total;
        byte_base  = byte_total;
        mem_base   = mem_idx;
        rd_cnt     = cnt;
        grp_dis    = dis;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_total == done_base && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("readout %s: strobes=%0d bytes=%0d done_at=%0d", tag,
                 rd_total - rd_base, byte_total - byte_base, last_done_cyc - start_cyc + 1);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp [8], input int n);
        check({tag, "_nbytes"}, 64'(byte_total - byte_base), 64'(n));
        for (int i = 0; i < n; i++)
            check({tag, "_byte"}, 64'(byte_log[(byte_base + i) & 255]), 64'(exp[i]));
    endtask

    initial begin
        logic [7:0] exp [8];
        rst_n = 1'b0; start = 1'b0; rd_cnt = '0; grp_dis = '0; tx_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem_data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Two full samples, all lanes enabled
        mem_data[0] = 32'hA1B2C3D4;
        mem_data[1] = 32'h11223344;
        start_readout(6'd2, 4'b0000);
        #1 check("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 100);
        exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};
        check_bytes("t1", exp, 8);
        check("t1_strobes", 64'(rd_total - rd_base), 64'd2);
        check("t1_done_cnt", 64'(done_total - done_base), 64'd1);
        check("t1_done_cycle", 64'(last_done_cyc - start_cyc + 1), 64'd13);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Lanes 0 and 2 disabled
        mem_data[0] = 32'hDEADBEEF;
        start_readout(6'd1, 4'b0101);
        wait_done("t2", 100);
        exp = '{8'hBE, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes("t2", exp, 2);
        check("t2_strobes", 64'(rd_total - rd_base), 64'd1);

        // Backpressure on the second byte for three cycles
        mem_data[0] = 32'h55667788;
        start_readout(6'd1, 4'b0000);
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_done("t3", 100);
        exp = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes("t3", exp, 4);
        check("t3_strobes", 64'(rd_total - rd_base), 64'd1);
        check("t3_done_cycle", 64'(last_done_cyc - start_cyc + 1), 64'd10);

        // Zero count
        start_readout(6'd0, 4'b0000);
        wait_done("t4", 20);
        check("t4_strobes", 64'(rd_total - rd_base), 64'd0);
        check("t4_valid", 64'(valid_total - valid_base), 64'd0);
        check("t4_done_cycle", 64'(last_done_cyc - start_cyc + 1), 64'd1);

        // Maximum count with every lane disabled
        start_readout(6'd32, 4'hF);
        wait_done("t5", 200);
        check("t5_strobes", 64'(rd_total - rd_base), 64'd32);
        check("t5_valid", 64'(valid_total - valid_base), 64'd0);
        check("t5_done_cnt", 64'(done_total - done_base), 64'd1);
        check("t5_done_cycle", 64'(last_done_cyc - start_cyc + 1), 64'd65);

        // Second start while busy is ignored
        start_readout(6'd3, 4'b0000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rd_cnt = 6'd5; grp_dis = 4'b1111; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t6", 200);
        check("t6_strobes", 64'(rd_total - rd_base), 64'd3);
        check("t6_bytes", 64'(byte_total - byte_base), 64'd12);
        check("t6_done_cnt", 64'(done_total - done_base), 64'd1);

        // Reset during SEND aborts the readout
        start_readout(6'd2, 4'b0000);
        repeat (2) @(posedge clk);
        #1 check("t7_in_send", 64'(tx_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t7_tx_valid", 64'(tx_valid), 64'd0);
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_mem_read", 64'(mem_read), 64'd0);
        check("t7_tx_data", 64'(tx_data), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t7_strobes", 64'(rd_total - rd_base), 64'd1);
        check("t7_no_done", 64'(done_total - done_base), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_readout.md
# sample_readout

Readout engine for the logic analyzer's capture memory: after a capture completes, it pulls a programmed number of samples out of the sample RAM, one read strobe per sample, and serialises each sample into bytes for the byte-wide transmitter. It is the read-side counterpart of the capture-memory write path. It sits between the capture memory and the UART transmit interface and is started by the core controller once sampling stops.

## Interface
- WIDTH, 32, sample width in bits; must be a multiple of 8.
- DEPTH, 5, memory address width; the memory holds 2**DEPTH samples.
- clk_i  in  1  system clock.
- rst_in  in  1  reset; synchronous, active-low.
- start_i  in  1  single-cycle pulse that starts a readout; ignored while busy_o=1.
- rd_cnt_i  in  DEPTH+1  number of samples to read; sampled on the accepted start_i.
- grp_dis_i  in  WIDTH/8  per-byte disable mask (bit k=1 means byte k is skipped); sampled on the accepted start_i.
- mem_read_o  out  1  read strobe to the capture memory, one cycle per sample.
- mem_i  in  WIDTH  read data; valid exactly one cycle after mem_read_o.
- tx_data_o  out  8  byte to the transmitter.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  transmitter accepts the byte.
- busy_o  out  1  readout in progress.
- done_o  out  1  single-cycle pulse when the readout completes.

## Operation
- States: IDLE, FETCH, LATCH, SEND, DONE.
- IDLE: if start_i=1, capture rd_cnt_i into the remaining-samples counter and grp_dis_i into the mask register.
  - If the count is 0, go to DONE.
  - Otherwise go to FETCH.
- FETCH: assert mem_read_o for exactly one cycle, then go to LATCH.
- LATCH: register mem_i into the sample register and decrement the remaining-samples counter.
  - Select the lowest-index enabled byte.
  - If no byte is enabled, go to FETCH when the remaining count is non-zero, otherwise to DONE.
  - If at least one byte is enabled, go to SEND.
- SEND: hold tx_valid_o=1 with the selected byte; tx_data_o is sample[8k+7:8k].
  - On tx_valid_o & tx_ready_i, advance to the next higher enabled byte.
  - After the last enabled byte is accepted, go to FETCH when the remaining count is non-zero, otherwise to DONE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Byte order is LSB first. Disabled bytes are never presented.
- tx_data_o must stay stable while tx_valid_o=1 and tx_ready_i=0.
- start_i is ignored in every state except IDLE.
- rd_cnt_i and grp_dis_i changes after the accepted start have no effect.
- Reset values: state=IDLE and all outputs 0 (mem_read_o, tx_valid_o, tx_data_o=8'h00, busy_o, done_o).
- A reset in the middle of a readout aborts immediately: next cycle is IDLE, with no further strobes, no done_o and tx_valid_o=0.

## Timing
- The start pulse is sampled at edge 0.
- Cycle 1 (FETCH): mem_read_o=1.
- Cycle 2 (LATCH): mem_i is captured.
- Cycle 3: first tx_valid_o=1.
- With tx_ready_i held at 1, a full sample (4 enabled bytes) takes 6 cycles: FETCH, LATCH, then 4 SEND cycles.
- tx_valid_o stays high back-to-back across bytes within one sample. It is low during FETCH and LATCH.
- busy_o is 1 from the cycle after the accepted start through DONE inclusive, and 0 in IDLE.
- done_o is asserted in the cycle after the final handshake, or in the cycle after start when rd_cnt_i=0.
- Maximum count: rd_cnt_i = 2**DEPTH produces exactly 2**DEPTH strobes. The counter is DEPTH+1 bits and never wraps.

## Structure
- Add the state enum readout_state_t (IDLE, FETCH, LATCH, SEND, DONE) to logIP_pkg.
- Add a package function next_byte(mask, current) to logIP_pkg. It returns the next enabled byte index plus a "none" flag.
- No sub-module. A single module holds the FSM, the sample register, the byte index and the counter.

## Test plan
- rd_cnt=2, mask=0, ready=1, mem returns 32'hA1B2C3D4 then 32'h11223344 -> bytes D4,C3,B2,A1,44,33,22,11; exactly 2 mem_read_o pulses; done_o 13 cycles after start.
- rd_cnt=1, mask=4'b0101, data 32'hDEADBEEF -> bytes BE,DE only.
- Backpressure: rd_cnt=1, ready low for 3 cycles on the second byte -> tx_data_o holds that byte stable, no byte is lost or duplicated, no extra mem_read_o.
- Edge counts: rd_cnt=0 -> no strobes, no tx_valid_o, done_o pulse the cycle after start. rd_cnt=32 with mask=4'hF -> 32 strobes, no tx_valid_o, then done_o.
- Start while busy: second start_i is ignored and the strobe count still equals the first rd_cnt. Reset asserted during SEND -> outputs 0 next cycle and no done_o.
